sequence_detector_1011: RTL and testbench
=========================================

Name: sequence_detector_1011

Overview:
- Moore-type serial pattern detector. Samples one bit per clock on sequence_in and flags each occurrence of the bit pattern 1-0-1-1, first bit received first.
- Overlapping matches are detected by default.
- Used as a leaf block on any single-bit serial stream. The output is registered state decode with no combinational input-to-output path.

Parameters:
- OVERLAP, 1, 1 = suffix of a completed match may seed the next match; 0 = after a match, detection restarts from scratch.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted). One clock; reset is asynchronous and active-low.
- sequence_in  input  1  serial data bit; sampled on each rising clk edge.
- detected_out  output  1  high for exactly one clock cycle when the FSM is in the match state.

Behaviour:
- Reset: rst=0 forces state to IDLE immediately, independent of clk. detected_out=0 while rst=0.
- Leaving reset: the first rising edge with rst=1 samples sequence_in normally. There is no extra dead cycle.
- States: IDLE (nothing matched), S1 (seen 1), S10 (seen 10), S101 (seen 101), S1011 (full match).
- Transitions, listed as current state: input 0 -> next state / input 1 -> next state:
  - IDLE: 0 -> IDLE / 1 -> S1.
  - S1: 0 -> S10 / 1 -> S1.
  - S10: 0 -> IDLE / 1 -> S101.
  - S101: 0 -> S10 / 1 -> S1011.
  - S1011 with OVERLAP=1: 0 -> S10 / 1 -> S1.
  - S1011 with OVERLAP=0: 0 -> IDLE / 1 -> S1. The trailing 1 of a match starts a new candidate; it is never used as a mid-pattern bit.
- Output: detected_out = (state == S1011). It depends on state only (Moore).
- Latency: detected_out rises after the rising edge that samples the 4th pattern bit. It stays high for that one clock period and falls on the next edge, unless that edge completes another match.
  - With OVERLAP=1, a second match needs at least 3 more bits ("011"), so back-to-back pulses are never adjacent.
- State encoding is implementer's choice. Unused encodings must recover to IDLE on the next clock edge with detected_out=0.
- Reset mid-pattern: any partial match is discarded, and a match that was in progress does not complete after release.
- sequence_in must be stable around the rising edge. No input synchroniser is included.

Test Plan:
- Reset: hold rst=0 for 3 cycles with sequence_in toggling -> detected_out=0 throughout. Deassert, feed 1,0,1,1 -> detected_out=1 for exactly one cycle after the 4th bit's edge.
- Non-match: after reset, feed 0,0,1,0,1,0,1,0 then hold 0 for 10 cycles -> detected_out stays 0 the whole time.
- Overlap (OVERLAP=1): feed 1,0,1,1,0,1,1 -> two single-cycle pulses, after bit 4 and after bit 7. With OVERLAP=0, the same stream gives one pulse, after bit 4 only.
- Near-miss recovery: feed 1,0,1,0,1,1 -> exactly one pulse, after bit 6 (S101 on 0 goes to S10).
- Repeated ones: feed 1,1,1,0,1,1 -> one pulse after bit 6. Feed 1,0,0,1,0,1,1 -> one pulse after bit 7 (S10 on 0 returns to IDLE).
- Async reset mid-operation: feed 1,0,1, then pulse rst=0 between clock edges, then feed 1 -> no pulse. A fresh 1,0,1,1 afterwards -> one pulse.

Source files
------------

// File: rtl/sequence_detector_1011.sv
// Moore FSM that flags each occurrence of the serial pattern 1-0-1-1 (first bit first).
// OVERLAP selects whether the tail of a finished match can seed the next one.
module sequence_detector_1011 #(
    parameter int OVERLAP = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic sequence_in,
    output logic detected_out
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        S1    = 3'd1,
        S10   = 3'd2,
        S101  = 3'd3,
        S1011 = 3'd4
    } state_t;

    state_t r_state;
    state_t w_nextState;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Unused encodings fall through to the default and recover to IDLE.
    always_comb begin
        w_nextState = IDLE;
        case (r_state)
            IDLE:    w_nextState = sequence_in ? S1    : IDLE;
            S1:      w_nextState = sequence_in ? S1    : S10;
            S10:     w_nextState = sequence_in ? S101  : IDLE;
            S101:    w_nextState = sequence_in ? S1011 : S10;
            S1011: begin
                if (OVERLAP != 0) begin
                    w_nextState = sequence_in ? S1 : S10;
                end else begin
                    w_nextState = sequence_in ? S1 : IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    assign detected_out = (r_state == S1011);

endmodule

// File: tb/tb_sequence_detector_1011.sv
// Bench for sequence_detector_1011: overlapping and non-overlapping instances run side by side
// against a bit-history model, plus directed streams with hand-computed pulse positions.
module tb_sequence_detector_1011;

    logic clk;
    logic rst;
    logic sequence_in;
    logic detOv;
    logic detNo;

    int checks;
    int errors;

    sequence_detector_1011 #(.OVERLAP(1)) dutOv (
        .clk          (clk),
        .rst          (rst),
        .sequence_in  (sequence_in),
        .detected_out (detOv)
    );

    sequence_detector_1011 #(.OVERLAP(0)) dutNo (
        .clk          (clk),
        .rst          (rst),
        .sequence_in  (sequence_in),
        .detected_out (detNo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: a match is the last four bits equal to 1011; the non-overlapping
    // flavour also requires all four bits to arrive after the previous match.
    logic [3:0] histBits;
    int         bitsSinceReset;
    int         bitsSinceMatchNo;
    logic       expOv;
    logic       expNo;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            histBits         = 4'b0000;
            bitsSinceReset   = 0;
            bitsSinceMatchNo = 0;
            expOv            = 1'b0;
            expNo            = 1'b0;
        end else begin
            histBits         = {histBits[2:0], sequence_in};
            bitsSinceReset   = bitsSinceReset + 1;
            bitsSinceMatchNo = bitsSinceMatchNo + 1;
            expOv = (bitsSinceReset >= 4) && (histBits == 4'b1011);
            expNo = (bitsSinceMatchNo >= 4) && (histBits == 4'b1011);
            if (expNo) begin
                bitsSinceMatchNo = 0;
            end
        end
    end

    always @(negedge clk) begin
        checks = checks + 1;
        if (detOv !== expOv) begin
            errors = errors + 1;
            $display("[TB] FAIL modelOverlap t=%0t actual=%b required=%b", $time, detOv, expOv);
        end
        checks = checks + 1;
        if (detNo !== expNo) begin
            errors = errors + 1;
            $display("[TB] FAIL modelNoOverlap t=%0t actual=%b required=%b", $time, detNo, expNo);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks = checks + 1;
        if (actual !== required) begin
            errors = errors + 1;
            $display("[TB] FAIL %s actual=%b required=%b", name, actual, required);
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        #2 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            sequence_in = ~sequence_in;
            #1;
            checkOutput("resetHoldOv", {31'd0, detOv}, 32'd0);
            checkOutput("resetHoldNo", {31'd0, detNo}, 32'd0);
        end
        sequence_in = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
    endtask

    // Feeds seq MSB-first; mask bit for stream bit k is set when the output is high after k's edge.
    task automatic applyStimulus(input logic [31:0] seq, input int len,
                                 output logic [31:0] maskOv, output logic [31:0] maskNo);
        maskOv = '0;
        maskNo = '0;
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            sequence_in = seq[len-1-i];
            @(posedge clk);
            #1;
            maskOv[len-1-i] = detOv;
            maskNo[len-1-i] = detNo;
        end
    endtask

    logic [31:0] mOv;
    logic [31:0] mNo;

    initial begin
        checks      = 0;
        errors      = 0;
        rst         = 1'b1;
        sequence_in = 1'b0;
        #1 rst = 1'b0;
        #1 checkOutput("initialResetOv", {31'd0, detOv}, 32'd0);

        doReset();
        applyStimulus(32'b1011, 4, mOv, mNo);
        checkOutput("firstMatchOv", mOv, 32'b0001);
        checkOutput("firstMatchNo", mNo, 32'b0001);
        applyStimulus(32'b0, 1, mOv, mNo);
        checkOutput("pulseFallsOv", mOv, 32'b0);

        doReset();
        applyStimulus(32'b001010100000000000, 18, mOv, mNo);
        checkOutput("nonMatchOv", mOv, 32'b0);
        checkOutput("nonMatchNo", mNo, 32'b0);

        doReset();
        applyStimulus(32'b1011011, 7, mOv, mNo);
        checkOutput("overlapOv", mOv, 32'b0001001);
        checkOutput("overlapNo", mNo, 32'b0001000);

        doReset();
        applyStimulus(32'b10111011, 8, mOv, mNo);
        checkOutput("backToBackOv", mOv, 32'b00010001);
        checkOutput("backToBackNo", mNo, 32'b00010001);

        doReset();
        applyStimulus(32'b101011, 6, mOv, mNo);
        checkOutput("nearMissOv", mOv, 32'b000001);
        checkOutput("nearMissNo", mNo, 32'b000001);

        doReset();
        applyStimulus(32'b111011, 6, mOv, mNo);
        checkOutput("repeatOnesOv", mOv, 32'b000001);
        checkOutput("repeatOnesNo", mNo, 32'b000001);

        doReset();
        applyStimulus(32'b1001011, 7, mOv, mNo);
        checkOutput("s10ZeroOv", mOv, 32'b0000001);
        checkOutput("s10ZeroNo", mNo, 32'b0000001);

        doReset();
        applyStimulus(32'b101, 3, mOv, mNo);
        checkOutput("preAsyncOv", mOv, 32'b000);
        #1 rst = 1'b0;
        #1 checkOutput("asyncLowOv", {31'd0, detOv}, 32'd0);
        rst = 1'b1;
        applyStimulus(32'b1, 1, mOv, mNo);
        checkOutput("asyncDiscardOv", mOv, 32'b0);
        checkOutput("asyncDiscardNo", mNo, 32'b0);
        applyStimulus(32'b1011, 4, mOv, mNo);
        checkOutput("afterAsyncOv", mOv, 32'b0001);
        checkOutput("afterAsyncNo", mNo, 32'b0001);

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
